// File: rtl/uart_rx_framed.sv
// UART receiver: 2-FF synchroniser, mid-bit sampling with false-start rejection,
// optional parity, 1/2 stop bits, and NUM_WORDS words packed per ready/valid beat.
module uart_rx_framed #(
  parameter int CLOCKS_PER_PULSE = 4,
  parameter int BITS_PER_WORD    = 8,
  parameter int W_OUT            = 16,
  parameter int PARITY           = 0,
  parameter int STOP_BITS        = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rx,
  input  logic             m_ready,
  output logic             m_valid,
  output logic [W_OUT-1:0] m_data,
  output logic             m_parity_err,
  output logic             m_frame_err,
  output logic             m_overrun
);
  localparam int NUM_WORDS = W_OUT / BITS_PER_WORD;
  localparam int CW        = $clog2(CLOCKS_PER_PULSE);
  localparam int BCW       = $clog2(BITS_PER_WORD + 2);
  localparam int WCW       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BREAK} state_t;

  state_t                   r_state;
  logic [1:0]               r_sync;
  logic [CW-1:0]            r_cnt;
  logic [BCW-1:0]           r_bit;
  logic [WCW-1:0]           r_wcnt;
  logic [BITS_PER_WORD-1:0] r_shift;
  logic [W_OUT-1:0]         r_buf;
  logic                     r_perr;
  logic                     r_ferr;

  logic             w_rs;
  logic             w_tick;
  logic             w_half;
  logic             w_par_bad;
  logic             w_ferr;
  logic             w_last_stop;
  logic             w_last_word;
  logic             w_free;
  logic [W_OUT-1:0] w_beat;

  assign w_rs        = r_sync[1];
  assign w_tick      = (r_cnt == CW'(CLOCKS_PER_PULSE - 1));
  assign w_half      = (r_cnt == CW'(CLOCKS_PER_PULSE / 2 - 1));
  // Odd parity wants an odd total of ones over data + parity bit, even wants even.
  assign w_par_bad   = (PARITY == 1) ? ~(^{w_rs, r_shift}) : (^{w_rs, r_shift});
  assign w_ferr      = r_ferr | ~w_rs;
  assign w_last_stop = (r_bit == BCW'(STOP_BITS - 1));
  assign w_last_word = (r_wcnt == WCW'(NUM_WORDS - 1));
  assign w_free      = !m_valid || m_ready;

  // The final word goes straight into the beat, bypassing the slot buffer.
  always_comb begin
    w_beat = r_buf;
    w_beat[W_OUT-1 -: BITS_PER_WORD] = r_shift;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], rx};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_wcnt       <= '0;
      r_shift      <= '0;
      r_buf        <= '0;
      r_perr       <= 1'b0;
      r_ferr       <= 1'b0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_parity_err <= 1'b0;
      m_frame_err  <= 1'b0;
      m_overrun    <= 1'b0;
    end else begin
      m_overrun <= 1'b0;
      if (m_valid && m_ready) m_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (!w_rs) begin
          r_state <= S_START;
          r_cnt   <= '0;
        end
        S_START: if (w_half) begin
          r_cnt   <= '0;
          r_bit   <= '0;
          r_state <= w_rs ? S_IDLE : S_DATA;
        end else r_cnt <= r_cnt + 1'b1;
        S_DATA: if (w_tick) begin
          r_cnt   <= '0;
          r_shift <= BITS_PER_WORD'({w_rs, r_shift} >> 1);
          if (r_bit == BCW'(BITS_PER_WORD - 1)) begin
            r_bit   <= '0;
            r_state <= (PARITY != 0) ? S_PAR : S_STOP;
          end else r_bit <= r_bit + 1'b1;
        end else r_cnt <= r_cnt + 1'b1;
        S_PAR: if (w_tick) begin
          r_cnt   <= '0;
          if (w_par_bad) r_perr <= 1'b1;
          r_state <= S_STOP;
        end else r_cnt <= r_cnt + 1'b1;
        S_STOP: if (w_tick) begin
          r_cnt <= '0;
          if (!w_last_stop) begin
            r_bit  <= r_bit + 1'b1;
            r_ferr <= w_ferr;
          end else begin
            r_bit   <= '0;
            r_buf[r_wcnt*BITS_PER_WORD +: BITS_PER_WORD] <= r_shift;
            r_state <= w_rs ? S_IDLE : S_BREAK;
            if (w_last_word) begin
              r_wcnt <= '0;
              r_perr <= 1'b0;
              r_ferr <= 1'b0;
              if (w_free) begin
                m_valid      <= 1'b1;
                m_data       <= w_beat;
                m_parity_err <= r_perr;
                m_frame_err  <= w_ferr;
              end else m_overrun <= 1'b1;
            end else begin
              r_wcnt <= r_wcnt + 1'b1;
              r_ferr <= w_ferr;
            end
          end
        end else r_cnt <= r_cnt + 1'b1;
        // A held-low line yields nothing until it returns high.
        S_BREAK: if (w_rs) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
